// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the normalization datapath.
package fp_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned MANT_W  = FRAC_W + 2;   // carry + hidden one + fraction
  localparam int unsigned SHIFT_W = 5;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic uflow;
    logic oflow;
  } flags_t;

  // Assemble an IEEE-754 single from its fields.
  function automatic logic [31:0] pack_float(input logic s,
                                             input logic [EXP_W-1:0] e,
                                             input logic [FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/mantissa_normalizer.sv
// Post-adder mantissa normalizer: one-bit-per-cycle left shift, carry
// right shift, zero/underflow/overflow detection, packed single output.
module mantissa_normalizer
  import fp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [MANT_W-1:0]  in_mant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_float,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_zero,
  output logic               out_uflow,
  output logic               out_oflow
);

  state_t               state_q, state_d;
  logic                 pend_q, pend_d;
  logic                 sign_q, sign_d;
  logic [EXP_W-1:0]     exp_q, exp_d;
  logic [MANT_W-1:0]    mant_q, mant_d;
  logic [SHIFT_W-1:0]   cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          float_q, float_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  flags_t               flags_q, flags_d;

  // Next-state and datapath: an accepted operand sits one cycle in IDLE
  // (pend_q) before being routed, which gives the 1 / n+2 cycle latencies.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    cnt_d       = cnt_q;
    float_d     = float_q;
    shift_d     = shift_q;
    flags_d     = flags_q;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = DONE;
          shift_d = '0;
          flags_d = '0;
          if (mant_q == '0) begin
            float_d      = pack_float(sign_q, '0, '0);
            flags_d.zero = 1'b1;
          end else if (exp_q == EXP_MAX) begin
            float_d       = pack_float(sign_q, EXP_MAX, '0);
            flags_d.oflow = 1'b1;
          end else if (mant_q[MANT_W-1]) begin
            if (exp_q == EXP_MAX - 8'd1) begin
              float_d       = pack_float(sign_q, EXP_MAX, '0);
              flags_d.oflow = 1'b1;
            end else begin
              float_d = pack_float(sign_q, exp_q + 8'd1, mant_q[FRAC_W:1]);
            end
          end else if (exp_q == '0) begin
            float_d       = pack_float(sign_q, '0, '0);
            flags_d.uflow = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end else if (in_valid && in_ready_q) begin
          pend_d = 1'b1;
          sign_d = in_sign;
          exp_d  = in_exp;
          mant_d = in_mant;
          cnt_d  = '0;
        end
      end

      SHIFT: begin
        if (mant_q[FRAC_W]) begin
          state_d = DONE;
          float_d = pack_float(sign_q, exp_q, mant_q[FRAC_W-1:0]);
          shift_d = cnt_q;
          flags_d = '0;
        end else if (exp_q == 8'd1) begin
          state_d       = DONE;
          float_d       = pack_float(sign_q, '0, '0);
          shift_d       = cnt_q;
          flags_d       = '0;
          flags_d.uflow = 1'b1;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - 8'd1;
          cnt_d  = cnt_q + 5'd1;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE) && !pend_d;
    out_valid_d = (state_d == DONE);
  end

  // State and registered outputs; reset clears everything including in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      float_q     <= '0;
      shift_q     <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      float_q     <= float_d;
      shift_q     <= shift_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_float = float_q;
  assign out_shift = shift_q;
  assign out_zero  = flags_q.zero;
  assign out_uflow = flags_q.uflow;
  assign out_oflow = flags_q.oflow;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed bench for mantissa_normalizer with hand-computed results.
module tb_mantissa_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_float;
  logic [4:0]  out_shift;
  logic        out_zero, out_uflow, out_oflow;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mantissa_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_uflow (out_uflow),
    .out_oflow (out_oflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] flags3();
    return {29'd0, out_zero, out_uflow, out_oflow};
  endfunction

  task automatic wait_ready(input string tag);
    int i;
    for (i = 0; i < 40 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Accept edge -> count edges until out_valid, check result, then handshake.
  task automatic run(input string tag, input logic s, input logic [7:0] e,
                     input logic [24:0] m, input logic [31:0] want_f,
                     input logic [4:0] want_sh, input logic [2:0] want_fl,
                     input int want_lat);
    int lat;
    wait_ready(tag);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sign = ~s; in_exp = ~e; in_mant = ~m;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(want_lat));
    check({tag, "_float"}, out_float, want_f);
    check({tag, "_shift"}, 32'(out_shift), 32'(want_sh));
    check({tag, "_flags"}, flags3(), 32'(want_fl));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic        saw;
    int          lat;

    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_float", out_float, 32'd0);
    check("rst_shift", 32'(out_shift), 32'd0);
    check("rst_flags", flags3(), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    #1 check("rst_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_ready_first_edge", 32'(in_ready), 32'd1);

    //   tag          s     exp     mant          float          sh     flags  lat
    run("norm",      1'b0, 8'd127, 25'h0800000, 32'h3F800000, 5'd0,  3'b000, 2);
    run("carry",     1'b0, 8'd127, 25'h1000000, 32'h40000000, 5'd0,  3'b000, 1);
    run("carry_ovf", 1'b0, 8'd254, 25'h1000000, 32'h7F800000, 5'd0,  3'b001, 1);
    run("maxshift",  1'b0, 8'd127, 25'h0000001, 32'h34000000, 5'd23, 3'b000, 25);
    run("zero",      1'b1, 8'd127, 25'h0000000, 32'h80000000, 5'd0,  3'b100, 1);
    run("uflow",     1'b0, 8'd5,   25'h0000100, 32'h00000000, 5'd4,  3'b010, 6);
    run("exp0",      1'b1, 8'd0,   25'h0400000, 32'h80000000, 5'd0,  3'b010, 1);
    run("exp255",    1'b0, 8'd255, 25'h0800000, 32'h7F800000, 5'd0,  3'b001, 1);
    run("mid",       1'b1, 8'd130, 25'h00ABCDE, 32'hBF2BCDE0, 5'd4,  3'b000, 6);
    run("carry_trn", 1'b0, 8'd100, 25'h1FFFFFF, 32'h32FFFFFF, 5'd0,  3'b000, 1);
    run("exp1",      1'b0, 8'd1,   25'h0400000, 32'h00000000, 5'd0,  3'b010, 2);
    run("exp2",      1'b0, 8'd2,   25'h0400000, 32'h00800000, 5'd1,  3'b000, 3);

    // Backpressure: result must hold for 10 cycles with in_ready low.
    wait_ready("bp");
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 25'h0800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd2);
    held = out_float;
    check("bp_float", held, 32'h3F800000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_float", out_float, 32'h3F800000);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset mid-SHIFT: operand discarded, no output afterwards.
    wait_ready("rif");
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 25'h0000001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rif_valid", 32'(out_valid), 32'd0);
    check("rif_ready", 32'(in_ready), 32'd0);
    check("rif_float", out_float, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rif_ready_first_edge", 32'(in_ready), 32'd1);
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("rif_no_output", 32'(saw), 32'd0);
    run("rif_fresh", 1'b1, 8'd130, 25'h00ABCDE, 32'hBF2BCDE0, 5'd4, 3'b000, 6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mantissa_normalizer.md
MANTISSA_NORMALIZER -- requirements
Module: mantissa_normalizer

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock for all state.
REQ-002 SHALL have port: rst_n input 1, reset, asynchronous, active-low.
REQ-003 SHALL have port: in_valid input 1, unnormalized operand present.
REQ-004 SHALL have port: in_ready output 1, block can accept an operand.
REQ-005 SHALL have port: in_sign input 1, result sign.
REQ-006 SHALL have port: in_exp input 8, biased exponent before normalization.
REQ-007 SHALL have port: in_mant input 25, adder sum; bit 24 = carry-out, bit 23 = hidden-one position.
REQ-008 SHALL have port: out_valid output 1, packed result present.
REQ-009 SHALL have port: out_ready input 1, consumer accepts result.
REQ-010 SHALL have port: out_float output 32, IEEE-754 single {sign, exp, frac}.
REQ-011 SHALL have port: out_shift output 5, number of left shifts applied (0..23).
REQ-012 SHALL have ports: out_zero, out_uflow and out_oflow, each output 1, result flags.

Function
REQ-013 SHALL use FSM states IDLE, SHIFT and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 SHALL accept an operand when in_valid && in_ready; operand, sign and exponent are registered and the shift count is cleared.
REQ-015 SHALL route the accepted operand from IDLE as follows:
- in_mant == 0 -> DONE, zero result.
- in_mant[24] == 1 -> mantissa right-shifted 1, exp + 1 -> DONE.
- in_exp == 0 -> DONE, underflow.
- otherwise -> SHIFT.
REQ-016 SHALL, in SHIFT, each cycle:
- mant[23] == 1 -> DONE.
- else exp == 1 -> DONE, underflow.
- else mant shifted left 1, exp - 1, count + 1.
REQ-017 SHALL produce a normal result {sign, exp[7:0], mant[22:0]}; excess bits are truncated, with no rounding.
REQ-018 SHALL produce a zero result {sign, 31'b0} with out_zero = 1.
REQ-019 SHALL produce an underflow result {sign, 31'b0} with out_uflow = 1 (flush-to-zero).
REQ-020 SHALL produce an overflow result {sign, 8'hFF, 23'b0} with out_oflow = 1 when the carry increment yields exp 255 or in_exp == 255.
REQ-021 SHALL meet these latencies, measured from the accept edge to out_valid high:
- 1 cycle for the zero, carry, overflow and exp==0 routes.
- n + 2 cycles for an operand with n leading zeros below bit 24.
- worst case 25 cycles.
REQ-022 SHALL hold all outputs stable in DONE until out_ready; on out_valid && out_ready it returns to IDLE.
REQ-023 SHALL NOT accept a new operand in the same cycle as the output handshake; the earliest next accept is the following cycle.
REQ-024 SHALL ignore in_* changes outside the accept cycle.

Reset
REQ-025 SHALL, while rst_n = 0, force the state to IDLE and all registers to 0, immediately and independent of clk.
REQ-026 SHALL, during reset, drive out_valid = 0, out_float = 0, out_shift = 0, all flags 0 and in_ready = 0.
REQ-027 SHALL, on a reset asserted mid-SHIFT or in DONE, discard the operand in flight with no output; in_ready rises on the first clk edge after deassertion.

Structure
REQ-028 SHALL take the state enum, EXP_W = 8, FRAC_W = 23, EXP_MAX = 8'hFF and the flag struct from shared package fp_pkg.
REQ-029 SHALL be a single module; the one-bit shift/decrement step stays inline and no sub-module is instantiated.

Verification
REQ-030 SHALL cover the normalized case: sign 0, exp 127, mant 25'h0800000 -> out_float 32'h3F800000, shift 0, out_valid 2 cycles after accept.
REQ-031 SHALL cover the carry cases:
- exp 127, mant 25'h1000000 -> 32'h40000000, shift 0, latency 1.
- exp 254, same mant -> 32'h7F800000, out_oflow = 1.
REQ-032 SHALL cover the maximum shift: exp 127, mant 25'h0000001 -> 32'h34000000, shift 23, latency 25.
REQ-033 SHALL cover zero and underflow:
- sign 1, mant 0 -> 32'h80000000, out_zero = 1.
- exp 5, mant 25'h0000100 -> 32'h00000000, out_uflow = 1 after 4 shifts.
REQ-034 SHALL cover backpressure: out_ready held 0 for 10 cycles -> outputs stable and in_ready = 0 throughout; release -> IDLE next cycle.
REQ-035 SHALL cover reset in flight: rst_n pulsed low mid-SHIFT -> out_valid never rises; a fresh operand then normalizes correctly.
